sirv_gnrl_fifo: RTL and testbench

Parameterized synchronous valid/ready FIFO. Its storage is built from per-entry load-enabled, reset-to-zero flop banks. It sits between a producer and a consumer stage in the general-purpose datapath, decoupling their handshakes and optionally cutting the combinational ready path. Data enters on the input handshake and leaves in order on the output handshake, one word per cycle per side.

---
 rtl/sirv_gnrl_fifo_if.sv | 23 ++
 rtl/sirv_gnrl_fifo.sv | 93 +++++++++
 tb/tb_sirv_gnrl_fifo.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sirv_gnrl_fifo_if.sv
// Valid/ready handshake bundle for sirv_gnrl_fifo: producer side (i_*) and
// consumer side (o_*). The FIFO takes the slave view; its neighbours take
// the master view.
interface sirv_gnrl_fifo_if #(
  parameter int unsigned DW = 32
);
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat
  );

  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat
  );
endinterface

// File: rtl/sirv_gnrl_fifo.sv
// Synchronous valid/ready FIFO of DP entries x DW bits. Storage is a bank of
// load-enabled, reset-to-zero registers; the head entry is muxed out from
// registered state only, so a word is never bypassed to o_dat in the cycle
// it is written. CUT_READY=1 removes the o_rdy -> i_rdy combinational path.
module sirv_gnrl_fifo #(
  parameter int unsigned DP        = 8,
  parameter int unsigned DW        = 32,
  parameter bit          CUT_READY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  sirv_gnrl_fifo_if.slave  bus
);

  localparam int unsigned   PW       = (DP > 1) ? $clog2(DP) : 1;
  localparam int unsigned   CW       = $clog2(DP + 1);
  localparam logic [PW-1:0] LAST     = PW'(DP - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DP);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;
  logic          full;

  assign full      = (cnt == FULL_CNT);
  assign push      = bus.i_vld & bus.i_rdy;
  assign pop       = bus.o_vld & bus.o_rdy;
  assign bus.o_vld = (cnt != '0);
  assign bus.o_dat = head;

  // With the cut, a full FIFO refuses writes even while it is being drained;
  // without it, a pop frees the slot the write lands in during the same cycle.
  generate
    if (CUT_READY) begin : g_cut_ready
      assign bus.i_rdy = ~full;
    end else begin : g_pass_ready
      assign bus.i_rdy = ~full | bus.o_rdy;
    end
  endgenerate

  // Write and read pointers, each wrapping at DP-1 independently.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage entries: only the entry under wptr loads, and only on a push.
  // NOTE: the entries are deliberately reset so o_dat reads zero after reset
  // and no stale word survives a mid-stream reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DP); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DP); i++) begin
        if (push && (wptr == PW'(i))) mem[i] <= bus.i_dat;
      end
    end
  end

  // Head-of-queue read mux from registered state.
  // NOTE: head gets a default before the loop so no latch is inferred.
  always_comb begin
    head = '0;
    for (int i = 0; i < int'(DP); i++) begin
      if (rptr == PW'(i)) head = mem[i];
    end
  end

endmodule

// File: tb/tb_sirv_gnrl_fifo.sv
// Self-checking bench for sirv_gnrl_fifo. Several parameterisations run side
// by side; directed tables and sequences cover the corner cases, and a
// queue-based reference model checks randomized traffic.
module tb_sirv_gnrl_fifo;

  localparam int NI = 6;

  // Instance set: 0 DP4/cut, 1 DP4/pass, 2 DP3/pass, 3 DP1/cut, 4 DP1/pass,
  // 5 DP5/pass.
  function automatic int dp_of(int k);
    case (k)
      0, 1:    return 4;
      2:       return 3;
      3, 4:    return 1;
      default: return 5;
    endcase
  endfunction

  function automatic bit cut_of(int k);
    return (k == 0) || (k == 3);
  endfunction

  logic       clk;
  logic       rst_n;
  logic       vld  [NI];
  logic       rdy  [NI];
  logic [7:0] dat  [NI];
  logic       irdy [NI];
  logic       ovld [NI];
  logic [7:0] odat [NI];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sirv_gnrl_fifo_if #(.DW(8)) bus ();

    sirv_gnrl_fifo #(
      .DP        (dp_of(g)),
      .DW        (8),
      .CUT_READY (cut_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.i_vld = vld[g];
    assign bus.i_dat = dat[g];
    assign bus.o_rdy = rdy[g];
    assign irdy[g]   = bus.i_rdy;
    assign ovld[g]   = bus.o_vld;
    assign odat[g]   = bus.o_dat;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs right after a falling edge; outputs settle by #1.
  task automatic apply(input int k, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    vld[k] = v;
    dat[k] = d;
    rdy[k] = r;
    #1;
  endtask

  typedef struct {
    int         k;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       e_irdy;
    logic       e_ovld;
    logic       chk_dat;
    logic [7:0] e_dat;
  } vec_t;

  function automatic vec_t mk(int k, logic v, logic [7:0] d, logic r,
                              logic e_irdy, logic e_ovld, logic chk_dat, logic [7:0] e_dat);
    vec_t t;
    t.k = k; t.v = v; t.d = d; t.r = r;
    t.e_irdy = e_irdy; t.e_ovld = e_ovld; t.chk_dat = chk_dat; t.e_dat = e_dat;
    return t;
  endfunction

  // Reference model: an ordered queue of words with capacity DP. Drives
  // traffic on instance k for n cycles, then drains. mode 0 keeps i_vld and
  // o_rdy high; mode 1 randomizes them (i_vld held until accepted).
  task automatic run_model(input int k, input int n, input bit mode, output int pushes);
    logic [7:0] q[$];
    logic       v = 1'b0;
    logic [7:0] d = 8'h00;
    logic       r;
    logic       e_vld, e_rdy;
    int         dp = dp_of(k);
    bit         cut = cut_of(k);
    pushes = 0;
    for (int c = 0; c < n + dp + 2; c++) begin
      if (c < n) begin
        if (!v) begin
          v = mode ? 1'($urandom_range(0, 1)) : 1'b1;
          d = 8'($urandom);
        end
        r = mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        v = 1'b0;
        r = 1'b1;
      end
      apply(k, v, d, r);
      e_vld = (q.size() != 0);
      e_rdy = (q.size() < dp) || (!cut && r);
      check($sformatf("model%0d c%0d i_rdy", k, c), 32'(irdy[k]), 32'(e_rdy));
      check($sformatf("model%0d c%0d o_vld", k, c), 32'(ovld[k]), 32'(e_vld));
      if (e_vld) check($sformatf("model%0d c%0d o_dat", k, c), 32'(odat[k]), 32'(q[0]));
      if (e_vld && r) void'(q.pop_front());
      if (v && e_rdy) q.push_back(d);
      if (v && irdy[k]) begin
        if (c < n) pushes++;
        v = 1'b0;
      end
    end
    vld[k] = 1'b0;
    rdy[k] = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    int   pushes;

    // Fill/drain on DP4 with the ready cut: fifth push rejected when full.
    tbl.push_back(mk(0, 1, 8'hA0, 0, 1, 0, 1, 8'h00));
    tbl.push_back(mk(0, 1, 8'hA1, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 8'hA2, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 8'hA3, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 1, 8'hA4, 0, 0, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 8'hA0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hA1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hA2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hA3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h00));
    // Full with simultaneous push/pop on DP4 without the cut.
    tbl.push_back(mk(1, 1, 8'hA0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 8'hA1, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(1, 1, 8'hA2, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(1, 1, 8'hA3, 0, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(1, 1, 8'hB0, 1, 1, 1, 1, 8'hA0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 1, 8'hA1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 8'hA1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 8'hA2));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 8'hA3));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 8'hB0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 8'h00));

    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      rdy[k] = 1'b0;
      dat[k] = 8'h00;
    end

    // Reset state while rst_n is low, released between clock edges.
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset%0d i_rdy", k), 32'(irdy[k]), 32'd1);
      check($sformatf("reset%0d o_vld", k), 32'(ovld[k]), 32'd0);
      check($sformatf("reset%0d o_dat", k), 32'(odat[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Idle with o_rdy=1 and no data: nothing moves.
    for (int c = 0; c < 3; c++) begin
      apply(0, 1'b0, 8'h00, 1'b1);
      check($sformatf("idle c%0d o_vld", c), 32'(ovld[0]), 32'd0);
      check($sformatf("idle c%0d i_rdy", c), 32'(irdy[0]), 32'd1);
      check($sformatf("idle c%0d o_dat", c), 32'(odat[0]), 32'd0);
    end
    rdy[0] = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].k, tbl[i].v, tbl[i].d, tbl[i].r);
      check($sformatf("tbl%0d i_rdy", i), 32'(irdy[tbl[i].k]), 32'(tbl[i].e_irdy));
      check($sformatf("tbl%0d o_vld", i), 32'(ovld[tbl[i].k]), 32'(tbl[i].e_ovld));
      if (tbl[i].chk_dat)
        check($sformatf("tbl%0d o_dat", i), 32'(odat[tbl[i].k]), 32'(tbl[i].e_dat));
    end
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0;
      rdy[k] = 1'b0;
    end

    // Wrap on DP3: stream 0..9, each word out one cycle after its push.
    for (int i = 0; i < 12; i++) begin
      apply(2, i < 10, 8'(i), 1'b1);
      check($sformatf("wrap%0d i_rdy", i), 32'(irdy[2]), 32'd1);
      check($sformatf("wrap%0d o_vld", i), 32'(ovld[2]), 32'(i >= 1 && i <= 10));
      if (i >= 1 && i <= 10)
        check($sformatf("wrap%0d o_dat", i), 32'(odat[2]), 32'(i - 1));
    end
    vld[2] = 1'b0;
    rdy[2] = 1'b0;

    // Asynchronous reset mid-stream on DP4 holding two words.
    apply(1, 1'b1, 8'hD0, 1'b0);
    apply(1, 1'b1, 8'hD1, 1'b0);
    apply(1, 1'b0, 8'h00, 1'b0);
    check("midrst before o_vld", 32'(ovld[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst during o_vld", 32'(ovld[1]), 32'd0);
    check("midrst during o_dat", 32'(odat[1]), 32'd0);
    #1;
    rst_n = 1'b1;
    apply(1, 1'b1, 8'hC0, 1'b0);
    check("midrst after o_vld", 32'(ovld[1]), 32'd0);
    check("midrst after i_rdy", 32'(irdy[1]), 32'd1);
    apply(1, 1'b0, 8'h00, 1'b0);
    check("midrst push o_vld", 32'(ovld[1]), 32'd1);
    check("midrst push o_dat", 32'(odat[1]), 32'hC0);
    apply(1, 1'b0, 8'h00, 1'b1);
    check("midrst pop o_dat", 32'(odat[1]), 32'hC0);
    apply(1, 1'b0, 8'h00, 1'b0);
    check("midrst empty o_vld", 32'(ovld[1]), 32'd0);

    // DP1 throughput: half rate with the cut, full rate without.
    run_model(3, 8, 1'b0, pushes);
    check("dp1 cut pushes in 8 cycles", 32'(pushes), 32'd4);
    run_model(4, 8, 1'b0, pushes);
    check("dp1 pass pushes in 8 cycles", 32'(pushes), 32'd8);

    // Randomized traffic against the queue model.
    run_model(5, 400, 1'b1, pushes);
    run_model(0, 400, 1'b1, pushes);
    run_model(2, 300, 1'b1, pushes);
    run_model(3, 200, 1'b1, pushes);
    run_model(4, 200, 1'b1, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
